entity_store: RTL and testbench

Writable, parametrised entity table that replaces the fixed dummy entity ROM. The renderer reads entries through the same synchronous read port and count output as before. A command port lets game logic append, overwrite, delete and clear entries at run time. Each entry is {type, x, y}. Entries at or above the live count read as zero.

---
 rtl/entity_pkg.sv | 30 +++
 rtl/entity_ram.sv | 33 +++
 rtl/entity_store.sv | 210 +++++++++++++++++++++
 tb/tb_entity_store.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/entity_pkg.sv
// Shared entity table definitions: field widths, command opcodes, entry layout and type codes.
// MOVE support in entity_store is enabled by defining ENTITY_STORE_MOVE_EN.
package entity_pkg;

    localparam int unsigned ENT_TYPE_W  = 3;
    localparam int unsigned ENT_COORD_W = 9;
    localparam int unsigned ENT_W       = ENT_TYPE_W + 2 * ENT_COORD_W;

    typedef enum logic [2:0] {
        OP_APPEND = 3'b000,
        OP_WRITE  = 3'b001,
        OP_DELETE = 3'b010,
        OP_CLEAR  = 3'b011,
        OP_MOVE   = 3'b100
    } cmd_op_e;

    typedef struct packed {
        logic [ENT_TYPE_W-1:0]  etype;
        logic [ENT_COORD_W-1:0] x;
        logic [ENT_COORD_W-1:0] y;
    } entity_t;

    // Type codes shared with the renderer
    localparam logic [ENT_TYPE_W-1:0] ENT_NONE   = 3'd0;
    localparam logic [ENT_TYPE_W-1:0] ENT_PLAYER = 3'd1;
    localparam logic [ENT_TYPE_W-1:0] ENT_ENEMY  = 3'd2;
    localparam logic [ENT_TYPE_W-1:0] ENT_WALL   = 3'd3;
    localparam logic [ENT_TYPE_W-1:0] ENT_ITEM   = 3'd4;

endpackage

// File: rtl/entity_ram.sv
// Entity storage: masked registered renderer read, async internal read, single write port.
module entity_ram #(
    parameter int unsigned ENT_W  = 21,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [ENT_W-1:0]  rd_data,
    input  logic [ADDR_W-1:0] src_addr,
    output logic [ENT_W-1:0]  src_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ENT_W-1:0]  wr_data
);

    logic [ENT_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the live-count mask hides stale entries
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= rd_en ? mem[rd_addr] : '0;
    end

    assign src_data = mem[src_addr];

endmodule

// File: rtl/entity_store.sv
// Run-time writable entity table with append/write/delete/clear commands for the renderer.
// Optional MOVE command (relative coordinate update) enabled by ENTITY_STORE_MOVE_EN.
module entity_store
    import entity_pkg::*;
#(
    parameter int unsigned TYPE_W  = ENT_TYPE_W,
    parameter int unsigned COORD_W = ENT_COORD_W,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           address_read_ent,
    output logic [TYPE_W+2*COORD_W-1:0] data_read_ent,
    output logic [CNT_W-1:0]            entities_number,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [ADDR_W-1:0]           cmd_index,
    input  logic [TYPE_W+2*COORD_W-1:0] cmd_data,
    output logic                        cmd_err,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned EW = TYPE_W + 2 * COORD_W;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEL_MOVE = 2'd1;
`ifdef ENTITY_STORE_MOVE_EN
    localparam logic [1:0] S_MV_READ  = 2'd2;
    localparam logic [1:0] S_MV_WRITE = 2'd3;
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [EW-1:0]     wdata_c;
    logic [ADDR_W-1:0] src_addr_c;
    logic [EW-1:0]     src_data;
    logic [ADDR_W-1:0] last_addr_c;
    logic              in_range_c;
    logic              rd_en_c;
    cmd_op_e           op_c;

`ifdef ENTITY_STORE_MOVE_EN
    logic [2*COORD_W-1:0] delta_q, delta_d;
    logic [EW-1:0]        mv_ent_q, mv_ent_d;
    logic [COORD_W-1:0]   mv_x_c, mv_y_c;
`endif

    assign op_c        = cmd_op_e'(cmd_op);
    assign in_range_c  = CNT_W'(cmd_index) < count_q;
    assign rd_en_c     = CNT_W'(address_read_ent) < count_q;
    assign last_addr_c = ADDR_W'(count_q - CNT_W'(1));

`ifdef ENTITY_STORE_MOVE_EN
    assign src_addr_c = (state_q == S_DEL_MOVE) ? last_addr_c : idx_q;
    assign mv_x_c = mv_ent_q[2*COORD_W-1:COORD_W] + delta_q[2*COORD_W-1:COORD_W];
    assign mv_y_c = mv_ent_q[COORD_W-1:0] + delta_q[COORD_W-1:0];
`else
    assign src_addr_c = last_addr_c;
`endif

    // Command decode and FSM next state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        idx_d   = idx_q;
        we_c    = 1'b0;
        waddr_c = cmd_index;
        wdata_c = cmd_data;
`ifdef ENTITY_STORE_MOVE_EN
        delta_d  = delta_q;
        mv_ent_d = mv_ent_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    case (op_c)
                        OP_APPEND: begin
                            if (full) begin
                                err_d = 1'b1;
                            end else begin
                                we_c    = 1'b1;
                                waddr_c = ADDR_W'(count_q);
                                count_d = count_q + CNT_W'(1);
                            end
                        end
                        OP_WRITE: begin
                            if (!in_range_c) err_d = 1'b1;
                            else             we_c  = 1'b1;
                        end
                        OP_DELETE: begin
                            if (!in_range_c) begin
                                err_d = 1'b1;
                            end else if (cmd_index == last_addr_c) begin
                                count_d = count_q - CNT_W'(1);
                            end else begin
                                idx_d   = cmd_index;
                                ready_d = 1'b0;
                                state_d = S_DEL_MOVE;
                            end
                        end
                        OP_CLEAR: count_d = '0;
`ifdef ENTITY_STORE_MOVE_EN
                        OP_MOVE: begin
                            if (!in_range_c) begin
                                err_d = 1'b1;
                            end else begin
                                idx_d   = cmd_index;
                                delta_d = cmd_data[2*COORD_W-1:0];
                                ready_d = 1'b0;
                                state_d = S_MV_READ;
                            end
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            // Swap-with-last: fill the hole with the final entry, then shrink
            S_DEL_MOVE: begin
                we_c    = 1'b1;
                waddr_c = idx_q;
                wdata_c = src_data;
                count_d = count_q - CNT_W'(1);
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
`ifdef ENTITY_STORE_MOVE_EN
            S_MV_READ: begin
                mv_ent_d = src_data;
                state_d  = S_MV_WRITE;
            end
            S_MV_WRITE: begin
                we_c    = 1'b1;
                waddr_c = idx_q;
                wdata_c = {mv_ent_q[EW-1:2*COORD_W], mv_x_c, mv_y_c};
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

`ifdef ENTITY_STORE_MOVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_q  <= '0;
            mv_ent_q <= '0;
        end else begin
            delta_q  <= delta_d;
            mv_ent_q <= mv_ent_d;
        end
    end
`endif

    entity_ram #(
        .ENT_W (EW),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (address_read_ent),
        .rd_en   (rd_en_c),
        .rd_data (data_read_ent),
        .src_addr(src_addr_c),
        .src_data(src_data),
        .we      (we_c),
        .wr_addr (waddr_c),
        .wr_data (wdata_c)
    );

    assign entities_number = count_q;
    assign cmd_ready       = ready_q;
    assign cmd_err         = err_q;
    assign full            = (count_q == CNT_W'(DEPTH));
    assign empty           = (count_q == '0);

endmodule

// File: tb/tb_entity_store.sv
// Directed bench for entity_store with an array/count reference model and per-cycle output compare.
module tb_entity_store;
    import entity_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned CNTW  = 9;
    localparam int unsigned EW    = 21;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   address_read_ent;
    logic [EW-1:0]   data_read_ent;
    logic [CNTW-1:0] entities_number;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [AW-1:0]   cmd_index;
    logic [EW-1:0]   cmd_data;
    logic            cmd_err;
    logic            full;
    logic            empty;

    entity_store dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .address_read_ent(address_read_ent),
        .data_read_ent   (data_read_ent),
        .entities_number (entities_number),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_index       (cmd_index),
        .cmd_data        (cmd_data),
        .cmd_err         (cmd_err),
        .full            (full),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] mmem [DEPTH];
    int            mcnt = 0;
    bit            busy = 1'b1;
    bit            chk_on = 1'b0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int t, input int x, input int y);
        entity_t e;
        e.etype = 3'(t);
        e.x     = 9'(x);
        e.y     = 9'(y);
        return e;
    endfunction

    // Reference model: commands take effect atomically on the table
    task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] idx,
                               input logic [EW-1:0] d, output bit err, output int lat);
        entity_t e, dl;
        err = 1'b0;
        lat = 0;
        case (op)
            3'b000: if (mcnt == DEPTH) err = 1'b1; else begin mmem[mcnt] = d; mcnt++; end
            3'b001: if (int'(idx) >= mcnt) err = 1'b1; else mmem[idx] = d;
            3'b010: begin
                if (int'(idx) >= mcnt) err = 1'b1;
                else begin
                    if (int'(idx) != mcnt - 1) begin
                        mmem[idx] = mmem[mcnt-1];
                        lat = 1;
                    end
                    mcnt--;
                end
            end
            3'b011: mcnt = 0;
`ifdef ENTITY_STORE_MOVE_EN
            3'b100: begin
                if (int'(idx) >= mcnt) err = 1'b1;
                else begin
                    e  = mmem[idx];
                    dl = d;
                    e.x = e.x + dl.x;
                    e.y = e.y + dl.y;
                    mmem[idx] = e;
                    lat = 2;
                end
            end
`endif
            default: err = 1'b1;
        endcase
    endtask

    // Per-cycle compare against the model whenever no command is in flight
    logic [AW-1:0] ck_addr;
    bit            ck_skip;
    always begin
        @(posedge clk);
        ck_addr = address_read_ent;
        ck_skip = busy || !chk_on;
        #2;
        if (!ck_skip) begin
            chk("rd_data", 32'(data_read_ent), (int'(ck_addr) < mcnt) ? 32'(mmem[ck_addr]) : 32'd0);
            chk("count", 32'(entities_number), 32'(mcnt));
            chk("full", 32'(full), 32'(mcnt == DEPTH));
            chk("empty", 32'(empty), 32'(mcnt == 0));
            chk("ready_idle", 32'(cmd_ready), 32'd1);
            chk("err_idle", 32'(cmd_err), 32'd0);
        end
    end

    task automatic cmd(input logic [2:0] op, input logic [AW-1:0] idx, input logic [EW-1:0] d);
        bit e;
        int lat;
        int low;
        @(negedge clk);
        busy = 1'b1;
        model_apply(op, idx, d, e, lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_index = idx;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_err", 32'(cmd_err), 32'(e));
        low = 0;
        while (!cmd_ready && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(low), 32'(lat));
        busy = 1'b0;
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [EW-1:0] exp);
        @(negedge clk);
        address_read_ent = a;
        @(negedge clk);
        chk(name, 32'(data_read_ent), 32'(exp));
    endtask

    logic [EW-1:0] ea, eb, ec;

    initial begin
        rst_n = 1'b0;
        address_read_ent = '0;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
        cmd_index = '0;
        cmd_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_data", 32'(data_read_ent), 32'd0);
        chk("rst_count", 32'(entities_number), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_err", 32'(cmd_err), 32'd0);
        busy = 1'b0;
        chk_on = 1'b1;

        // Basic append and masked reads
        cmd(3'b000, '0, ent(3, 0, 48));
        cmd(3'b000, '0, ent(4, 48, 96));
        chk("count_2", 32'(entities_number), 32'd2);
        rd("rd_addr1", 8'd1, {3'd4, 9'd48, 9'd96});
        rd("rd_addr2", 8'd2, 21'd0);
        rd("rd_addr0", 8'd0, {3'd3, 9'd0, 9'd48});

        // WRITE in range, at count (rejected), reserved op
        cmd(3'b001, 8'd1, ent(2, 100, 200));
        rd("rd_write", 8'd1, {3'd2, 9'd100, 9'd200});
        cmd(3'b001, 8'd2, ent(7, 1, 1));
        cmd(3'b111, 8'd0, ent(7, 7, 7));
        cmd(3'b101, 8'd0, ent(7, 7, 7));
        chk("count_after_rej", 32'(entities_number), 32'd2);

        // Swap-with-last delete
        ea = ent(1, 10, 11);
        eb = ent(2, 20, 21);
        ec = ent(3, 30, 31);
        cmd(3'b011, '0, '0);
        cmd(3'b000, '0, ea);
        cmd(3'b000, '0, eb);
        cmd(3'b000, '0, ec);
        cmd(3'b001, 8'd3, ea);
        cmd(3'b010, 8'd0, '0);
        chk("del_count", 32'(entities_number), 32'd2);
        rd("del_addr0", 8'd0, {3'd3, 9'd30, 9'd31});
        rd("del_addr1", 8'd1, {3'd2, 9'd20, 9'd21});
        cmd(3'b010, 8'd1, '0);
        chk("del_last_count", 32'(entities_number), 32'd1);
        cmd(3'b010, 8'd1, '0);

        // Fill to capacity
        cmd(3'b011, '0, '0);
        for (int i = 0; i < DEPTH; i++) cmd(3'b000, '0, ent(i % 8, i, 511 - i));
        chk("full_flag", 32'(full), 32'd1);
        cmd(3'b000, '0, ent(5, 5, 5));
        chk("full_count", 32'(entities_number), 32'd256);
        rd("full_last", 8'd255, {3'd7, 9'd255, 9'd256});
        cmd(3'b010, 8'd7, '0);
        rd("full_del", 8'd7, {3'd7, 9'd255, 9'd256});

        // Reset during DEL_MOVE
        cmd(3'b011, '0, '0);
        cmd(3'b000, '0, ea);
        cmd(3'b000, '0, eb);
        cmd(3'b000, '0, ec);
        @(negedge clk);
        busy = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'b010;
        cmd_index = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("delmv_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        mcnt = 0;
        #1;
        chk("midrst_count", 32'(entities_number), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 1'b0;
        cmd(3'b000, '0, ea);
        cmd(3'b000, '0, eb);
        rd("post_rst_a1", 8'd1, {3'd2, 9'd20, 9'd21});

        // CLEAR masks everything
        cmd(3'b011, '0, '0);
        rd("clr_a0", 8'd0, 21'd0);
        rd("clr_a1", 8'd1, 21'd0);

        // MOVE with negative dx
        cmd(3'b000, '0, ent(1, 5, 10));
        cmd(3'b100, 8'd0, {3'd0, 9'h1FA, 9'd2});
`ifdef ENTITY_STORE_MOVE_EN
        rd("move_res", 8'd0, {3'd1, 9'd511, 9'd12});
        cmd(3'b100, 8'd1, {3'd0, 9'd1, 9'd1});
`else
        rd("move_res", 8'd0, {3'd1, 9'd5, 9'd10});
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
